emin_param: RTL

- Parametrised successor to the order-2 minimum-residual-energy engine.
- For a segment end index i, it streams Emin(j,i) for every j in [j_min, i]. It fetches the prefix autocorrelation triples T(0..2, ·) from an external T store with configurable read latency.
- Compared with the previous generation, it adds:
  - configurable fixed-point scaling, read latency and index depth;
  - a start/busy/done handshake;
  - a programmable j start index;
  - a degenerate-denominator flag;
  - defined saturation.
- It sits between the T BRAM and the Emin buffer writer in the formant pipeline.

---
 rtl/emin_param.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/emin_param.sv
// Order-2 minimum-residual-energy engine: streams Emin(j,i) for j in [j_min, i]
// from prefix autocorrelation triples fetched out of an external T store.
module emin_param #(
  parameter int BIT_WIDTH = 32,
  parameter int FRAC_BITS = 2,
  parameter int I         = 160,
  parameter int T_LAT     = 2,
  localparam int IW       = $clog2(I)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [IW-1:0]          i_in,
  input  logic [IW-1:0]          j_min_in,
  output logic                   busy_out,
  output logic [IW-1:0]          T_req_addr,
  output logic                   T_req_valid,
  input  logic [3*BIT_WIDTH-1:0] T_resp,
  output logic [IW-1:0]          j_out,
  output logic [BIT_WIDTH-1:0]   data_out,
  output logic                   degen_out,
  output logic                   output_valid,
  output logic                   done_out
);
  localparam int W2 = 2 * BIT_WIDTH;
  localparam logic [W2-1:0] QMAX = {{(BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};

  typedef logic signed [BIT_WIDTH-1:0] sw_t;
  typedef enum logic [1:0] {IDLE, FETCH_I, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic          v;
    logic          fetch;
    logic          zero;
    logic          last;
    logic [IW-1:0] j;
  } tag_t;

  typedef struct packed {
    logic          v;
    logic          last;
    logic [IW-1:0] j;
  } rtag_t;

  function automatic sw_t mul(input sw_t a, input sw_t b);
    logic signed [W2-1:0] p;
    p = W2'(a) * W2'(b);
    p = p >>> FRAC_BITS;
    return sw_t'(p[BIT_WIDTH-1:0]);
  endfunction

  // Sign/magnitude division; caller guarantees d > 0.
  function automatic sw_t sdiv(input sw_t n, input sw_t d);
    logic signed [W2-1:0] ns;
    logic [W2-1:0]        mag;
    logic [W2-1:0]        den;
    logic [W2-1:0]        q;
    ns  = W2'(n) <<< FRAC_BITS;
    mag = ns[W2-1] ? -ns : ns;
    den = W2'(d);
    q   = mag / den;
    if (q > QMAX) q = QMAX;
    return ns[W2-1] ? -sw_t'(q[BIT_WIDTH-1:0]) : sw_t'(q[BIT_WIDTH-1:0]);
  endfunction

  state_t        state;
  logic [IW-1:0] i_q, jmin_q, j_cnt;
  tag_t          tag0;
  tag_t          dly [T_LAT];
  tag_t          rt;

  sw_t   ti0, ti1, ti2, tj0, tj1, tj2;
  rtag_t s0_t, s1_t, s2_t;
  sw_t   s0_r0, s0_r1, s0_r2;
  sw_t   s1_r0, s1_r1, s1_r2, s1_an, s1_bn, s1_d;
  sw_t   s2_r0, s2_r1, s2_r2, s2_alpha, s2_beta;
  logic  s2_degen;
  sw_t   emin_c;

  // Tag marking which T_resp cycle belongs to which request.
  assign rt = dly[T_LAT-1];

  always_comb begin
    tj0 = '0;
    tj1 = '0;
    tj2 = '0;
    if (!rt.zero) begin
      tj0 = sw_t'(T_resp[BIT_WIDTH-1:0]);
      tj1 = sw_t'(T_resp[2*BIT_WIDTH-1:BIT_WIDTH]);
      tj2 = sw_t'(T_resp[3*BIT_WIDTH-1:2*BIT_WIDTH]);
    end
  end

  always_comb begin
    emin_c = s2_r0 - mul(s2_r1, s2_alpha) - mul(s2_r2, s2_beta);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned k = 0; k < T_LAT; k++) dly[k] <= '0;
      {ti0, ti1, ti2} <= '0;
      s0_t <= '0; s1_t <= '0; s2_t <= '0;
      {s0_r0, s0_r1, s0_r2} <= '0;
      {s1_r0, s1_r1, s1_r2, s1_an, s1_bn, s1_d} <= '0;
      {s2_r0, s2_r1, s2_r2, s2_alpha, s2_beta} <= '0;
      s2_degen <= 1'b0;
    end else begin
      dly[0] <= tag0;
      for (int unsigned k = 1; k < T_LAT; k++) dly[k] <= dly[k-1];
      if (rt.fetch) begin
        ti0 <= sw_t'(T_resp[BIT_WIDTH-1:0]);
        ti1 <= sw_t'(T_resp[2*BIT_WIDTH-1:BIT_WIDTH]);
        ti2 <= sw_t'(T_resp[3*BIT_WIDTH-1:2*BIT_WIDTH]);
      end
      s0_t  <= '{v: rt.v, last: rt.last, j: rt.j};
      s0_r0 <= ti0 - tj0;
      s0_r1 <= ti1 - tj1;
      s0_r2 <= ti2 - tj2;

      s1_t  <= s0_t;
      s1_r0 <= s0_r0;
      s1_r1 <= s0_r1;
      s1_r2 <= s0_r2;
      s1_an <= mul(s0_r0, s0_r1) - mul(s0_r1, s0_r2);
      s1_bn <= mul(s0_r0, s0_r2) - mul(s0_r1, s0_r1);
      s1_d  <= mul(s0_r0, s0_r0) - mul(s0_r1, s0_r1);

      s2_t  <= s1_t;
      s2_r0 <= s1_r0;
      s2_r1 <= s1_r1;
      s2_r2 <= s1_r2;
      if (s1_d > 0) begin
        s2_alpha <= sdiv(s1_an, s1_d);
        s2_beta  <= sdiv(s1_bn, s1_d);
        s2_degen <= 1'b0;
      end else begin
        s2_alpha <= '0;
        s2_beta  <= '0;
        s2_degen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      busy_out     <= 1'b0;
      T_req_addr   <= '0;
      T_req_valid  <= 1'b0;
      j_out        <= '0;
      data_out     <= '0;
      degen_out    <= 1'b0;
      output_valid <= 1'b0;
      done_out     <= 1'b0;
      i_q          <= '0;
      jmin_q       <= '0;
      j_cnt        <= '0;
      tag0         <= '0;
    end else begin
      T_req_valid  <= 1'b0;
      tag0         <= '0;
      output_valid <= s2_t.v;
      done_out     <= s2_t.v && s2_t.last;
      degen_out    <= s2_t.v && s2_degen;
      j_out        <= s2_t.v ? s2_t.j : '0;
      data_out     <= s2_t.v ? emin_c : '0;
      case (state)
        IDLE: begin
          busy_out <= 1'b0;
          // busy_out still high in the done cycle, so a start there is ignored.
          if (start_in && !busy_out) begin
            i_q         <= i_in;
            jmin_q      <= j_min_in;
            busy_out    <= 1'b1;
            T_req_addr  <= i_in;
            T_req_valid <= 1'b1;
            tag0.fetch  <= 1'b1;
            state       <= FETCH_I;
          end
        end
        FETCH_I: begin
          if (rt.fetch) begin
            if (jmin_q > i_q) begin
              done_out <= 1'b1;
              state    <= IDLE;
            end else begin
              j_cnt <= jmin_q;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          T_req_addr  <= (j_cnt == '0) ? '0 : j_cnt - IW'(1);
          T_req_valid <= (j_cnt != '0);
          tag0        <= '{v: 1'b1, fetch: 1'b0, zero: (j_cnt == '0),
                           last: (j_cnt == i_q), j: j_cnt};
          j_cnt       <= j_cnt + IW'(1);
          if (j_cnt == i_q) state <= DRAIN;
        end
        DRAIN: begin
          if (s2_t.v && s2_t.last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
